// File: rtl/ota_pdm_driver_if.sv
// Valid/ready code handshake between the top-level pin logic (master) and
// the OTA PDM driver (slave).
interface ota_pdm_driver_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] code;
    logic             valid;
    logic             ready;

    modport master (output code, output valid, input ready);
    modport slave  (input code, input valid, output ready);
endinterface

// File: rtl/ota_pdm_driver.sv
// First-order PDM stimulus driver for the on-chip OTA/comparator, with a double-buffered code input.
// Optional comparator loopback counter is enabled by defining OTA_PDM_LOOPBACK_EN.
module ota_pdm_driver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena_i,
    input  logic             run_en_i,
    ota_pdm_driver_if.slave  code_if,
`ifdef OTA_PDM_LOOPBACK_EN
    input  logic             cmp_in_i,
    output logic [WIDTH:0]   cmp_count_o,
    output logic             cmp_valid_o,
`endif
    output logic             pdm_p_o,
    output logic             pdm_n_o,
    output logic             frame_strobe_o,
    output logic             busy_o
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             pdm_p_q, pdm_p_d;
    logic             pdm_n_q, pdm_n_d;
    logic             strobe_q, strobe_d;

    logic             xfer;
    logic             last;
    logic             carry;
    logic [WIDTH-1:0] acc_sum;

    assign xfer = ena_i && code_if.valid && !pend_valid_q;
    assign last = (cnt_q == '1);
    // The accumulator overflow is the output bit; acc restarts each frame so ones == code.
    assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, active_q};

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch can leave a latch behind.
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        active_d     = active_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        pdm_p_d      = pdm_p_q;
        pdm_n_d      = pdm_n_q;
        strobe_d     = strobe_q;
        if (ena_i) begin
            strobe_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    pdm_p_d = 1'b0;
                    pdm_n_d = 1'b0;
                    if (xfer) begin
                        active_d = code_if.code;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = RUN;
                    end
                end
                RUN: begin
                    pdm_p_d = carry;
                    pdm_n_d = ~carry;
                    acc_d   = acc_sum;
                    cnt_d   = cnt_q + WIDTH'(1);
                    if (xfer) begin
                        pend_d       = code_if.code;
                        pend_valid_d = 1'b1;
                    end
                    if (last) begin
                        strobe_d = 1'b1;
                        acc_d    = '0;
                        cnt_d    = '0;
                        if (pend_valid_q) begin
                            active_d     = pend_q;
                            pend_valid_d = 1'b0;
                        end else if (!run_en_i && !xfer) begin
                            // A code arriving on this edge replays the current one a frame longer.
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            active_q     <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            pdm_p_q      <= 1'b0;
            pdm_n_q      <= 1'b0;
            strobe_q     <= 1'b0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            pdm_p_q      <= pdm_p_d;
            pdm_n_q      <= pdm_n_d;
            strobe_q     <= strobe_d;
        end
    end

    assign code_if.ready  = !pend_valid_q;
    assign pdm_p_o        = pdm_p_q;
    assign pdm_n_o        = pdm_n_q;
    assign frame_strobe_o = strobe_q;
    assign busy_o         = (state_q == RUN);

`ifdef OTA_PDM_LOOPBACK_EN
    logic [1:0]     sync_q;
    logic [WIDTH:0] ones_q;
    logic [WIDTH:0] cmp_count_q;
    logic           cmp_valid_q;
    logic [WIDTH:0] ones_inc;

    assign ones_inc = ones_q + {{WIDTH{1'b0}}, sync_q[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            ones_q      <= '0;
            cmp_count_q <= '0;
            cmp_valid_q <= 1'b0;
        end else if (ena_i) begin
            sync_q      <= {sync_q[0], cmp_in_i};
            cmp_valid_q <= 1'b0;
            if (state_q == RUN) begin
                if (last) begin
                    cmp_count_q <= ones_inc;
                    ones_q      <= '0;
                    cmp_valid_q <= 1'b1;
                end else begin
                    ones_q <= ones_inc;
                end
            end else begin
                ones_q <= '0;
            end
        end
    end

    assign cmp_count_o = cmp_count_q;
    assign cmp_valid_o = cmp_valid_q;
`endif

endmodule
